intt_core: RTL



---
 rtl/intt_core_pkg.sv | 38 +++
 rtl/intt_core_if.sv | 32 +++
 rtl/intt_core_gs_butterfly.sv | 89 ++++++++
 rtl/intt_core.sv | 126 ++++++++++++
 4 files changed

// File: rtl/intt_core_pkg.sv
// Shared definitions for the inverse-NTT core: modulus table, Barrett constants,
// datapath widths, bank geometry and FSM state encoding.
package intt_core_pkg;

    localparam int DATA_W     = 30;
    localparam int COEF_W     = 30;
    localparam int ADDR_W     = 9;
    localparam int BANK_DEPTH = 512;
    localparam int LOG_M_MAX  = 9;
    localparam int STAGES     = 4;
    localparam int PROD_W     = DATA_W + COEF_W;
    localparam int BARRETT_K  = 60;
    localparam int MU_W       = 34;
    localparam int NUM_MODULI = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Index 0 is the rightmost entry.
    localparam logic [NUM_MODULI-1:0][DATA_W-1:0] Q_TABLE = {
        30'd1012924417, 30'd975175681,  30'd962592769,  30'd950009857,
        30'd943718401,  30'd985661441,  30'd1007681537, 30'd167772161,
        30'd469762049,  30'd754974721,  30'd1004535809, 30'd998244353,
        30'd1073479681
    };

    // Barrett constant mu = floor(2^60 / q) for the selected modulus.
    function automatic logic [MU_W-1:0] barrett_mu(input int idx);
        logic [63:0] num;
        num = 64'd1 << BARRETT_K;
        return MU_W'(num / {34'd0, Q_TABLE[idx]});
    endfunction

endpackage

// File: rtl/intt_core_if.sv
// Load, twiddle-ROM and result bus of intt_core; master is the host/ROM side.
interface intt_core_if;
    import intt_core_pkg::*;

    logic [3:0]          log_m;
    logic                start;
    logic                write_enable;
    logic [ADDR_W-1:0]   upper_write_address;
    logic [ADDR_W-1:0]   lower_write_address;
    logic [2*DATA_W-1:0] upper_data_input;
    logic [2*DATA_W-1:0] lower_data_input;
    logic [11:0]         twiddle_index;
    logic [COEF_W-1:0]   twiddle;
    logic                busy;
    logic                done;
    logic                out_valid;
    logic [ADDR_W-1:0]   out_addr;
    logic [DATA_W-1:0]   r1, r2, r3, r4;

    modport master (
        output log_m, start, write_enable, upper_write_address, lower_write_address,
               upper_data_input, lower_data_input, twiddle,
        input  twiddle_index, busy, done, out_valid, out_addr, r1, r2, r3, r4
    );

    modport slave (
        input  log_m, start, write_enable, upper_write_address, lower_write_address,
               upper_data_input, lower_data_input, twiddle,
        output twiddle_index, busy, done, out_valid, out_addr, r1, r2, r3, r4
    );

endinterface

// File: rtl/intt_core_gs_butterfly.sv
// Gentleman-Sande butterfly: A=(a+b) mod q, B=((a-b) mod q)*w mod q, three register stages.
// Optional INTT_HALVE_EN scales both results by 1/2 mod q in the last stage.
module gs_butterfly
    import intt_core_pkg::*;
#(
    parameter int MOD_INDEX = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_p2,
    input  logic [DATA_W-1:0] a_p0,
    input  logic [DATA_W-1:0] b_p0,
    input  logic [COEF_W-1:0] w_p0,
    output logic [DATA_W-1:0] a_p3,
    output logic [DATA_W-1:0] b_p3
);

    localparam logic [DATA_W-1:0] Q  = Q_TABLE[MOD_INDEX];
    localparam logic [MU_W-1:0]   MU = barrett_mu(MOD_INDEX);

    function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        logic [DATA_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        return DATA_W'(s);
    endfunction

    function automatic logic [DATA_W-1:0] sub_mod(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        if (x >= y) return x - y;
        return DATA_W'({1'b0, x} + {1'b0, Q} - {1'b0, y});
    endfunction

    // Quotient estimate is at most one short, so two corrections always reach < q.
    function automatic logic [DATA_W-1:0] barrett_reduce(input logic [PROD_W-1:0] x);
        logic [PROD_W+MU_W-1:0] m;
        logic [MU_W-1:0]        t;
        logic [63:0]            r;
        m = {{MU_W{1'b0}}, x} * {{PROD_W{1'b0}}, MU};
        t = MU_W'(m >> BARRETT_K);
        r = {4'd0, x} - ({30'd0, t} * {34'd0, Q});
        if (r >= {34'd0, Q}) r = r - {34'd0, Q};
        if (r >= {34'd0, Q}) r = r - {34'd0, Q};
        return DATA_W'(r);
    endfunction

`ifdef INTT_HALVE_EN
    function automatic logic [DATA_W-1:0] halve_mod(input logic [DATA_W-1:0] x);
        logic [DATA_W:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, Q}) : {1'b0, x};
        return DATA_W'(s >> 1);
    endfunction
`endif

    logic [DATA_W-1:0] sum_p1, diff_p1, sum_p2;
    logic [COEF_W-1:0] w_p1;
    logic [PROD_W-1:0] prod_p2;
    logic [DATA_W-1:0] a_fin, b_fin;

    // p1: modular add/sub; p2: full-width product
    always_ff @(posedge clk) begin
        sum_p1  <= add_mod(a_p0, b_p0);
        diff_p1 <= sub_mod(a_p0, b_p0);
        w_p1    <= w_p0;
        sum_p2  <= sum_p1;
        prod_p2 <= {{COEF_W{1'b0}}, diff_p1} * {{DATA_W{1'b0}}, w_p1};
    end

    always_comb begin
`ifdef INTT_HALVE_EN
        a_fin = halve_mod(sum_p2);
        b_fin = halve_mod(barrett_reduce(prod_p2));
`else
        a_fin = sum_p2;
        b_fin = barrett_reduce(prod_p2);
`endif
    end

    // p3: reduced results, held between valid samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p3 <= '0;
            b_p3 <= '0;
        end else if (vld_p2) begin
            a_p3 <= a_fin;
            b_p3 <= b_fin;
        end
    end

endmodule

// File: rtl/intt_core.sv
// One inverse-NTT stage pass over two 512-entry coefficient banks, 4-cycle pipeline.
// Build option: INTT_HALVE_EN enables final 1/2 mod q scaling inside gs_butterfly.
module intt_core
    import intt_core_pkg::*;
#(
    parameter int          MOD_INDEX      = 0,
    parameter logic [10:0] CORE_INDEX     = 11'd0,
    parameter int          LOG_CORE_COUNT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    intt_core_if.slave  bus
);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   rd_addr;
    logic [1:0]          drain_cnt;
    logic [3:0]          lm_q;
    logic [19:0]         core_term;
    logic [11:0]         tw_index;

    logic [2*DATA_W-1:0] upper_mem [BANK_DEPTH];
    logic [2*DATA_W-1:0] lower_mem [BANK_DEPTH];
    logic [2*DATA_W-1:0] upper_p0, lower_p0;
    logic [COEF_W-1:0]   tw_p0;
    logic [ADDR_W-1:0]   addr_p0, addr_p1, addr_p2, addr_p3;
    logic                vld_p0, vld_p1, vld_p2, vld_p3;
    logic [DATA_W-1:0]   r1_p3, r2_p3, r3_p3, r4_p3;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nx = ST_RUN;
            ST_RUN:   if (rd_addr == ADDR_W'(BANK_DEPTH - 1)) state_nx = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == 2'd3) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            drain_cnt <= '0;
            lm_q      <= '0;
        end else begin
            state     <= state_nx;
            rd_addr   <= (state == ST_RUN) ? rd_addr + 9'd1 : '0;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 2'd1 : '0;
            if (state == ST_IDLE && bus.start)
                lm_q <= (bus.log_m > 4'(LOG_M_MAX)) ? 4'(LOG_M_MAX) : bus.log_m;
        end
    end

    // Twiddle address: stage base + this core's offset + position within the stage.
    always_comb begin
        core_term = (20'(CORE_INDEX) << lm_q) >> LOG_CORE_COUNT;
        tw_index  = '0;
        if (state == ST_RUN)
            tw_index = (12'd1 << lm_q) + 12'(core_term) + 12'(rd_addr >> (4'd9 - lm_q));
    end

    // p0: bank read and twiddle capture; loads accepted only while idle
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.write_enable) begin
            upper_mem[bus.upper_write_address] <= bus.upper_data_input;
            lower_mem[bus.lower_write_address] <= bus.lower_data_input;
        end
        upper_p0 <= upper_mem[rd_addr];
        lower_p0 <= lower_mem[rd_addr];
        tw_p0    <= bus.twiddle;
        addr_p0  <= rd_addr;
        addr_p1  <= addr_p0;
        addr_p2  <= addr_p1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            addr_p3 <= '0;
        end else begin
            vld_p0 <= (state == ST_RUN);
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            if (vld_p2) addr_p3 <= addr_p2;
        end
    end

    gs_butterfly #(.MOD_INDEX(MOD_INDEX)) u_bfly_upper (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_p2 (vld_p2),
        .a_p0   (upper_p0[DATA_W-1:0]),
        .b_p0   (upper_p0[2*DATA_W-1:DATA_W]),
        .w_p0   (tw_p0),
        .a_p3   (r1_p3),
        .b_p3   (r2_p3)
    );

    gs_butterfly #(.MOD_INDEX(MOD_INDEX)) u_bfly_lower (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_p2 (vld_p2),
        .a_p0   (lower_p0[DATA_W-1:0]),
        .b_p0   (lower_p0[2*DATA_W-1:DATA_W]),
        .w_p0   (tw_p0),
        .a_p3   (r3_p3),
        .b_p3   (r4_p3)
    );

    assign bus.twiddle_index = tw_index;
    assign bus.busy          = (state == ST_RUN) || (state == ST_DRAIN);
    assign bus.done          = (state == ST_DONE);
    assign bus.out_valid     = vld_p3;
    assign bus.out_addr      = addr_p3;
    assign bus.r1            = r1_p3;
    assign bus.r2            = r2_p3;
    assign bus.r3            = r3_p3;
    assign bus.r4            = r4_p3;

endmodule
